// File: rtl/instruction_fetch_unit.sv
// Fetches 16-bit instructions as two byte reads (high byte at PC, low byte at PC+1) and hands them to decode.
// Delivery is valid/ready: an instruction stays held until decode accepts it, and a branch discards any partial or held fetch.
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          MEM_BYTES = 128
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [15:0] mem_address_o,
    output logic        mem_read_o,
    input  logic [7:0]  mem_data_i,
    output logic [15:0] instruction_o,
    output logic [15:0] instr_pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    input  logic        branch_taken_i,
    input  logic [15:0] branch_target_i,
    input  logic        halt_i,
    output logic [15:0] fetch_count_o
);

    localparam logic [15:0] ADDR_MASK = 16'(MEM_BYTES - 1);

    typedef enum logic [1:0] {
        FETCH_HI = 2'd0,
        FETCH_LO = 2'd1,
        HOLD     = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] instr_pc_q, instr_pc_d;
    logic        valid_q, valid_d;
    logic [15:0] count_q, count_d;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        handshake;

    assign handshake = valid_q & instr_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= FETCH_HI;
            pc_q       <= RESET_PC & ADDR_MASK;
            instr_q    <= 16'h0000;
            instr_pc_q <= 16'h0000;
            valid_q    <= 1'b0;
            count_q    <= 16'h0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        count_d    = count_q;
        mem_addr   = pc_q;
        mem_rd     = 1'b0;

        case (state_q)
            FETCH_HI: begin
                if (!halt_i) begin
                    mem_rd        = 1'b1;
                    instr_d[15:8] = mem_data_i;
                    state_d       = FETCH_LO;
                end
            end
            FETCH_LO: begin
                mem_addr     = (pc_q + 16'd1) & ADDR_MASK;
                mem_rd       = 1'b1;
                instr_d[7:0] = mem_data_i;
                instr_pc_d   = pc_q;
                valid_d      = 1'b1;
                pc_d         = (pc_q + 16'd2) & ADDR_MASK;
                state_d      = HOLD;
            end
            HOLD: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    count_d = count_q + 16'd1;
                    state_d = FETCH_HI;
                end
            end
            default: state_d = FETCH_HI;
        endcase

        // A redirect wins over everything except the handshake count, which has already been taken.
        if (branch_taken_i) begin
            pc_d    = {branch_target_i[15:1], 1'b0} & ADDR_MASK;
            valid_d = 1'b0;
            state_d = FETCH_HI;
        end
    end

    assign mem_address_o = mem_addr;
    assign mem_read_o    = mem_rd & ~rst_i;
    assign instruction_o = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = valid_q;
    assign fetch_count_o = count_q;

endmodule
